stream_vigenere_cipher: RTL and testbench
=========================================

# stream_vigenere_cipher

Streaming, parametrised successor to the team's fixed-length combinational encryptor. Accepts plaintext or ciphertext one byte per cycle on a valid/ready stream, applies a runtime-loadable Vigenère key of 1..MAX_KEY_LEN letters, and emits the result on an output stream. Supports encrypt and decrypt modes and messages of arbitrary length delimited by `last`. It sits between a byte source (UART/DMA) and a byte sink in the HardwareSec datapath.

## Interface
- `MAX_KEY_LEN`, 16, key storage depth in letters (≥1)
- `KIDX_W`, $clog2(MAX_KEY_LEN+1), width of key length/index
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous and active-low
- `key_clear` in 1: pulse; empties key (IDLE only)
- `key_wr_en` in 1: append `key_wr_data` to key (IDLE only)
- `key_wr_data` in 8: ASCII key letter, A–Z or a–z
- `key_len` out KIDX_W: number of stored key letters
- `key_err` out 1: one-cycle pulse on a rejected key write
- `cfg_decrypt` in 1: 0 = encrypt, 1 = decrypt; latched on the first beat of each message
- `s_valid` in 1, `s_ready` out 1, `s_data` in 8, `s_last` in 1: input stream
- `m_valid` out 1, `m_ready` in 1, `m_data` out 8, `m_last` out 1: output stream
- `busy` out 1: high in RUN

## Operation
- States: IDLE, RUN. IDLE→RUN on the first accepted input beat. RUN→IDLE on an accepted beat with `s_last`=1, including a single-beat message, which stays in IDLE.
- Key store: each letter is kept as shift 0..25 (`'A'`/`'a'`=0). A write is rejected with a `key_err` pulse and no change if the state is RUN, the store is full, or the byte is not a letter. `key_clear` in IDLE sets `key_len`=0. `key_clear` and `key_wr_en` in the same cycle: clear wins, write is dropped without error.
- Per beat, with shift k = key[kidx]:
  - Uppercase: out = 'A' + ((c−'A') ± k) mod 26. Lowercase uses the same rule with 'a'. Case is preserved.
  - Encrypt adds k. Decrypt subtracts k. Compute in 6-bit unsigned: sum ≥ 26 → subtract 26; difference < 0 → add 26.
  - Non-letter bytes pass through unchanged and do not advance kidx.
  - After a letter, kidx advances and wraps to 0 at `key_len`−1.
  - kidx resets to 0 at every message end.
- `key_len`=0: every byte passes through unchanged. This is not an error.
- `m_last` mirrors `s_last` of the same beat.

## Timing
- Latency: one cycle. An accepted beat at edge N is visible on `m_*` after edge N.
- `s_ready` = !`m_valid` || `m_ready` (combinational). Full throughput: one beat per cycle with `m_ready` held high.
- `m_valid`/`m_data`/`m_last` hold stable while `m_valid` && !`m_ready`.
- The mode is latched at first-beat acceptance. Changing `cfg_decrypt` mid-message has no effect until the next message.
- Reset values: `m_valid`=0, `m_data`=0, `m_last`=0, `key_len`=0, `key_err`=0, `busy`=0, state IDLE, kidx=0.
- Reset mid-message discards the output register and the key. Inputs during reset are ignored.

## Structure
- Package `cipher_pkg` holds:
  - `ALPHA_LEN`=26, ASCII constants `ASCII_A`/`ASCII_a`/`ASCII_Z`/`ASCII_z`
  - `cipher_state_e` {IDLE, RUN}
  - functions `is_upper`, `is_lower`
- Sub-module `vigenere_shift` (combinational): inputs byte, shift[4:0], decrypt; outputs byte and is_letter. It is instantiated once.
- The top level owns the key RAM (flops), kidx, FSM and output register.

## Test plan
- Key "KEY", encrypt "HELLO" (`s_last` on 'O') → "RIJVS", `m_last` on 'S', `busy` falls after the last beat.
- Key "KEY", decrypt "RIJVS" → "HELLO"; then encrypt "hello" → "rijvs".
- Key "BC", encrypt "A-B" → "B-D". Non-letters are unchanged and do not advance the key index.
- `MAX_KEY_LEN`=4: write "ABCDE" → `key_len`=4 and a `key_err` pulse on 'E'. Write '1' → `key_err`. `key_wr_en` during RUN → `key_err`, key unchanged.
- Key "KEY", 10-byte message with `m_ready` toggling in a random pattern → no lost or duplicated bytes, `m_data` held while stalled, output equals the reference model.
- Assert `rst_n` after 2 beats of "HELLO" → outputs return to their reset values and `key_len`=0. Reload "KEY" and resend "HELLO" → "RIJVS", proving kidx restarted at 0.

Source files
------------

// File: rtl/stream_vigenere_cipher_pkg.sv
// Shared constants, state encoding and ASCII helpers for the streaming Vigenere cipher.
package cipher_pkg;

  localparam logic [5:0] ALPHA_LEN = 6'd26;
  localparam logic [7:0] ASCII_A   = 8'h41;
  localparam logic [7:0] ASCII_Z   = 8'h5A;
  localparam logic [7:0] ASCII_a   = 8'h61;
  localparam logic [7:0] ASCII_z   = 8'h7A;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cipher_state_e;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= ASCII_A) && (c <= ASCII_Z);
  endfunction

  function automatic logic is_lower(input logic [7:0] c);
    return (c >= ASCII_a) && (c <= ASCII_z);
  endfunction

  function automatic logic is_letter(input logic [7:0] c);
    return is_upper(c) || is_lower(c);
  endfunction

  // Shift 0..25 of a key letter, case-insensitive.
  function automatic logic [4:0] letter_shift(input logic [7:0] c);
    return 5'(c - (is_upper(c) ? ASCII_A : ASCII_a));
  endfunction

endpackage

// File: rtl/stream_vigenere_cipher_if.sv
// Byte stream with valid/ready handshake and an end-of-message marker.
interface stream_vigenere_cipher_if;

  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic       last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/stream_vigenere_cipher_shift.sv
// Combinational Vigenere letter shifter; non-letters pass through untouched.
module vigenere_shift
  import cipher_pkg::*;
(
  input  logic [7:0] i_byte,
  input  logic [4:0] i_shift,
  input  logic       i_decrypt,
  output logic [7:0] o_byte,
  output logic       o_is_letter
);

  logic       w_upper;
  logic       w_lower;
  logic [7:0] w_base;
  logic [5:0] w_off;
  logic [5:0] w_k;
  logic [5:0] w_res;

  always_comb begin
    w_upper = is_upper(i_byte);
    w_lower = is_lower(i_byte);
    w_base  = w_upper ? ASCII_A : ASCII_a;
    w_off   = 6'(i_byte - w_base);
    w_k     = {1'b0, i_shift};
    // Both operands are below 26, so one conditional correction keeps the result in 0..25.
    if (i_decrypt) begin
      w_res = (w_off < w_k) ? (w_off + ALPHA_LEN - w_k) : (w_off - w_k);
    end else begin
      w_res = w_off + w_k;
      if (w_res >= ALPHA_LEN) begin
        w_res = w_res - ALPHA_LEN;
      end
    end
    o_is_letter = w_upper | w_lower;
    o_byte      = o_is_letter ? (w_base + {2'b00, w_res}) : i_byte;
  end

endmodule

// File: rtl/stream_vigenere_cipher.sv
// Streaming Vigenere encrypt/decrypt with a runtime-loadable key and a one-deep output register.
module stream_vigenere_cipher
  import cipher_pkg::*;
#(
  parameter int MAX_KEY_LEN = 16,
  parameter int KIDX_W      = $clog2(MAX_KEY_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_clear,
  input  logic                  key_wr_en,
  input  logic [7:0]            key_wr_data,
  output logic [KIDX_W-1:0]     key_len,
  output logic                  key_err,
  input  logic                  cfg_decrypt,
  stream_vigenere_cipher_if.slave  s,
  stream_vigenere_cipher_if.master m,
  output logic                  busy
);

  localparam int KADDR_W = (MAX_KEY_LEN > 1) ? $clog2(MAX_KEY_LEN) : 1;
  localparam logic [KIDX_W-1:0] KIDX_ONE = KIDX_W'(1);
  localparam logic [KIDX_W-1:0] KEY_FULL = KIDX_W'(MAX_KEY_LEN);

  cipher_state_e     r_state;
  cipher_state_e     w_next_state;
  logic [4:0]        r_key [MAX_KEY_LEN];
  logic [KIDX_W-1:0] r_key_len;
  logic [KIDX_W-1:0] r_kidx;
  logic [KIDX_W-1:0] w_kidx_next;
  logic              r_decrypt;
  logic              r_key_err;
  logic              r_m_valid;
  logic [7:0]        r_m_data;
  logic              r_m_last;

  logic              w_s_ready;
  logic              w_s_fire;
  logic              w_key_wr_req;
  logic              w_key_wr_ok;
  logic              w_key_wr_bad;
  logic              w_key_empty;
  logic [4:0]        w_shift;
  logic              w_decrypt;
  logic [7:0]        w_out_byte;
  logic              w_is_letter;

  assign w_s_ready = !r_m_valid || m.ready;
  assign w_s_fire  = s.valid && w_s_ready;

  // Key writes: a simultaneous clear silently drops the write.
  assign w_key_empty  = (r_key_len == '0);
  assign w_key_wr_req = key_wr_en && !key_clear;
  assign w_key_wr_ok  = w_key_wr_req && (r_state == IDLE) && (r_key_len != KEY_FULL)
                        && is_letter(key_wr_data);
  assign w_key_wr_bad = w_key_wr_req && !w_key_wr_ok;

  // The first beat of a message uses the live mode input; later beats use the latched copy.
  assign w_decrypt = (r_state == IDLE) ? cfg_decrypt : r_decrypt;
  assign w_shift   = w_key_empty ? 5'd0 : r_key[r_kidx[KADDR_W-1:0]];

  vigenere_shift u_shift (
    .i_byte      (s.data),
    .i_shift     (w_shift),
    .i_decrypt   (w_decrypt),
    .o_byte      (w_out_byte),
    .o_is_letter (w_is_letter)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: default assignment first so no path through the block leaves a latch behind.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_s_fire && !s.last) w_next_state = RUN;
      RUN:  if (w_s_fire && s.last)  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == RUN);
  end

  // NOTE: key RAM is left unreset; key_len gates every read, so stale letters are never used.
  always_ff @(posedge clk) begin
    if (w_key_wr_ok) begin
      r_key[r_key_len[KADDR_W-1:0]] <= letter_shift(key_wr_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_len <= '0;
      r_key_err <= 1'b0;
    end else begin
      r_key_err <= w_key_wr_bad;
      if (key_clear && (r_state == IDLE)) begin
        r_key_len <= '0;
      end else if (w_key_wr_ok) begin
        r_key_len <= r_key_len + KIDX_ONE;
      end
    end
  end

  always_comb begin
    w_kidx_next = r_kidx;
    if (w_s_fire) begin
      if (s.last) begin
        w_kidx_next = '0;
      end else if (w_is_letter && !w_key_empty) begin
        w_kidx_next = (r_kidx == r_key_len - KIDX_ONE) ? '0 : r_kidx + KIDX_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kidx    <= '0;
      r_decrypt <= 1'b0;
    end else begin
      r_kidx <= w_kidx_next;
      if (w_s_fire && (r_state == IDLE)) begin
        r_decrypt <= cfg_decrypt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_data  <= 8'h00;
      r_m_last  <= 1'b0;
    end else if (w_s_fire) begin
      r_m_valid <= 1'b1;
      r_m_data  <= w_out_byte;
      r_m_last  <= s.last;
    end else if (m.ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign s.ready = w_s_ready;
  assign m.valid = r_m_valid;
  assign m.data  = r_m_data;
  assign m.last  = r_m_last;
  assign key_len = r_key_len;
  assign key_err = r_key_err;

endmodule

// File: tb/tb_stream_vigenere_cipher.sv
// Self-checking bench: vector table, key-store corner cases, random backpressure and mid-message reset.
module tb_stream_vigenere_cipher;

  localparam int MAXK = 4;
  localparam int KW   = $clog2(MAXK + 1);

  typedef logic [7:0] bq_t[$];
  typedef struct {
    string key;
    bit    dec;
    string msg;
    string exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_clear = 1'b0;
  logic          key_wr_en = 1'b0;
  logic [7:0]    key_wr_data = 8'h00;
  logic          cfg_decrypt = 1'b0;
  logic [KW-1:0] key_len;
  logic          key_err;
  logic          busy;

  int  total = 0;
  int  bad   = 0;
  bq_t cur_key;

  stream_vigenere_cipher_if s_if ();
  stream_vigenere_cipher_if m_if ();

  stream_vigenere_cipher #(.MAX_KEY_LEN(MAXK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_clear   (key_clear),
    .key_wr_en   (key_wr_en),
    .key_wr_data (key_wr_data),
    .key_len     (key_len),
    .key_err     (key_err),
    .cfg_decrypt (cfg_decrypt),
    .s           (s_if),
    .m           (m_if),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic vec_t mk(input string k, input bit d, input string msg, input string e);
    vec_t v;
    v.key = k; v.dec = d; v.msg = msg; v.exp = e;
    return v;
  endfunction

  // Reference: classic Vigenere over letters with modulo-26 arithmetic.
  function automatic bq_t ref_cipher(input bq_t msg, input bq_t key, input bit dec);
    bq_t out;
    int  idx = 0;
    int  c, base, k;
    for (int i = 0; i < msg.size(); i++) begin
      c = int'(msg[i]);
      if (((c >= 65 && c <= 90) || (c >= 97 && c <= 122)) && key.size() > 0) begin
        base = (c >= 97) ? 97 : 65;
        k    = int'(key[idx]) - ((key[idx] >= 8'd97) ? 97 : 65);
        if (dec) k = 26 - k;
        out.push_back(8'(base + (c - base + k) % 26));
        idx = (idx + 1) % key.size();
      end else begin
        out.push_back(msg[i]);
      end
    end
    return out;
  endfunction

  task automatic key_write(input logic [7:0] b);
    key_wr_en = 1'b1; key_wr_data = b;
    @(posedge clk); #1;
    key_wr_en = 1'b0;
  endtask

  task automatic load_key(input bq_t k);
    key_clear = 1'b1;
    @(posedge clk); #1;
    key_clear = 1'b0;
    for (int i = 0; i < k.size(); i++) key_write(k[i]);
    check("key_len_loaded", 32'(key_len), k.size());
    cur_key = k;
  endtask

  task automatic run_msg(input string name, input bq_t msg, input bit dec, input bit rnd,
                         input bit flip, input bq_t exp);
    int         n = msg.size();
    int         sent = 0;
    int         cyc = 0;
    int         budget = 20 * msg.size() + 20;
    bq_t        rx;
    logic       lq[$];
    logic       stalled = 1'b0;
    logic [7:0] sd = 8'h00;
    logic       sl = 1'b0;
    cfg_decrypt = dec;
    while ((sent < n || rx.size() < n) && cyc < budget) begin
      s_if.valid = (sent < n);
      s_if.data  = (sent < n) ? msg[sent] : 8'h00;
      s_if.last  = (sent == n - 1);
      m_if.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      check({name, "_s_ready"}, 32'(s_if.ready), 32'(!m_if.valid || m_if.ready));
      if (stalled) begin
        check({name, "_stall_valid"}, 32'(m_if.valid), 1);
        check({name, "_stall_data"}, 32'(m_if.data), 32'(sd));
        check({name, "_stall_last"}, 32'(m_if.last), 32'(sl));
      end
      if (sent > 0 && sent < n) check({name, "_busy_mid"}, 32'(busy), 1);
      if (m_if.valid && m_if.ready) begin
        rx.push_back(m_if.data);
        lq.push_back(m_if.last);
      end
      stalled = m_if.valid && !m_if.ready;
      sd = m_if.data;
      sl = m_if.last;
      if (s_if.valid && s_if.ready) sent++;
      @(posedge clk); #1;
      if (flip && sent > 0) cfg_decrypt = !dec;
      cyc++;
    end
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    m_if.ready = 1'b1;
    cfg_decrypt = 1'b0;
    check({name, "_count"}, rx.size(), n);
    if (!rnd) check({name, "_cycles"}, cyc, n + 1);
    for (int i = 0; i < rx.size() && i < exp.size(); i++) begin
      check({name, "_data"}, 32'(rx[i]), 32'(exp[i]));
      check({name, "_last"}, 32'(lq[i]), 32'(i == n - 1));
    end
    check({name, "_busy_end"}, 32'(busy), 0);
  endtask

  initial begin
    vec_t vecs[8];
    bq_t  msg;
    bq_t  k;
    bit   dec;
    logic [7:0] bad_keys[4];

    s_if.valid = 1'b0; s_if.data = 8'h00; s_if.last = 1'b0;
    m_if.ready = 1'b1;

    vecs[0] = mk("KEY", 1'b0, "HELLO", "RIJVS");
    vecs[1] = mk("KEY", 1'b1, "RIJVS", "HELLO");
    vecs[2] = mk("KEY", 1'b0, "hello", "rijvs");
    vecs[3] = mk("BC",  1'b0, "A-B",   "B-D");
    vecs[4] = mk("",    1'b0, "Hi!",   "Hi!");
    vecs[5] = mk("KEY", 1'b0, "Z",     "J");
    vecs[6] = mk("KEY", 1'b0, "zY.a",  "jC.y");
    vecs[7] = mk("KEY", 1'b1, "abc",   "qxe");

    // Reset values
    #12;
    check("rst_m_valid", 32'(m_if.valid), 0);
    check("rst_m_data", 32'(m_if.data), 0);
    check("rst_m_last", 32'(m_if.last), 0);
    check("rst_key_len", 32'(key_len), 0);
    check("rst_key_err", 32'(key_err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_s_ready", 32'(s_if.ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      load_key(str2q(vecs[i].key));
      run_msg($sformatf("vec%0d", i), str2q(vecs[i].msg), vecs[i].dec, 1'b0, 1'b0,
              str2q(vecs[i].exp));
    end

    // Key store: overflow, non-letters, clear/write collision, lowercase accepted
    load_key(str2q("ABCD"));
    key_write("E");
    check("full_err", 32'(key_err), 1);
    check("full_len", 32'(key_len), 4);
    @(posedge clk); #1;
    check("err_pulse_end", 32'(key_err), 0);
    load_key(str2q(""));
    bad_keys[0] = 8'h40; bad_keys[1] = 8'h5B; bad_keys[2] = 8'h60; bad_keys[3] = 8'h7B;
    key_write("1");
    check("digit_err", 32'(key_err), 1);
    for (int i = 0; i < 4; i++) begin
      key_write(bad_keys[i]);
      check($sformatf("nonletter_err_%0h", bad_keys[i]), 32'(key_err), 1);
    end
    check("nonletter_len", 32'(key_len), 0);
    key_write("q");
    check("lower_ok_err", 32'(key_err), 0);
    check("lower_ok_len", 32'(key_len), 1);
    key_clear = 1'b1; key_wr_en = 1'b1; key_wr_data = "A";
    @(posedge clk); #1;
    key_clear = 1'b0; key_wr_en = 1'b0;
    check("clr_wr_len", 32'(key_len), 0);
    check("clr_wr_err", 32'(key_err), 0);

    // Key write while a message is in flight
    load_key(str2q("KEY"));
    m_if.ready = 1'b1;
    s_if.valid = 1'b1; s_if.data = "H"; s_if.last = 1'b0;
    @(posedge clk); #1;
    s_if.valid = 1'b0;
    check("run_first_valid", 32'(m_if.valid), 1);
    check("run_first_data", 32'(m_if.data), 32'("R"));
    check("run_busy", 32'(busy), 1);
    key_write("A");
    check("run_wr_err", 32'(key_err), 1);
    check("run_wr_len", 32'(key_len), 3);
    run_msg("run_rest", str2q("ELLO"), 1'b0, 1'b0, 1'b0, str2q("IJVS"));

    // Random messages under random backpressure
    for (int r = 0; r < 4; r++) begin
      k = {};
      if (r == 0) begin
        k = str2q("KEY");
      end else begin
        for (int i = 0; i < int'($urandom_range(1, MAXK)); i++)
          k.push_back(8'($urandom_range(0, 1) ? 65 : 97) + 8'($urandom_range(0, 25)));
      end
      msg = {};
      for (int i = 0; i < 10; i++) begin
        case ($urandom_range(0, 4))
          0, 1:    msg.push_back(8'(65 + $urandom_range(0, 25)));
          2, 3:    msg.push_back(8'(97 + $urandom_range(0, 25)));
          default: msg.push_back(8'($urandom_range(0, 255)));
        endcase
      end
      dec = (r == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      load_key(k);
      run_msg($sformatf("rand%0d", r), msg, dec, 1'b1, r >= 1, ref_cipher(msg, cur_key, dec));
    end

    // Reset in the middle of a message
    load_key(str2q("KEY"));
    m_if.ready = 1'b0;
    s_if.valid = 1'b1; s_if.data = "H"; s_if.last = 1'b0;
    @(posedge clk); #1;
    m_if.ready = 1'b1;
    s_if.data = "E";
    @(posedge clk); #1;
    s_if.valid = 1'b0;
    m_if.ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_m_valid", 32'(m_if.valid), 0);
    check("mid_rst_m_data", 32'(m_if.data), 0);
    check("mid_rst_m_last", 32'(m_if.last), 0);
    check("mid_rst_key_len", 32'(key_len), 0);
    check("mid_rst_busy", 32'(busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_if.ready = 1'b1;
    load_key(str2q("KEY"));
    run_msg("after_rst", str2q("HELLO"), 1'b0, 1'b0, 1'b0, str2q("RIJVS"));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
